// File: rtl/qsys_mailbox_pkg.sv
// qsys_mailbox_pkg: register map, STATUS layout, pending indices and slave FSM states for the host mailbox
package qsys_mailbox_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IRQ_EN = 2'd2;
  localparam logic [1:0] REG_IRQ_STAT = 2'd3;
  localparam int ST_H2F_LVL = 0;
  localparam int ST_F2H_LVL = 8;
  localparam int ST_H2F_FULL = 16;
  localparam int ST_F2H_EMPTY = 17;
  localparam int ST_OVF = 24;
  localparam int ST_UNF = 25;
  localparam int PND_F2H = 0;
  localparam int PND_H2F = 1;
  localparam int PND_ERR = 2;
  typedef enum logic [1:0] {S_IDLE, S_RESP, S_DRAIN} slv_state_e;
endpackage

// File: rtl/sc_fifo_fwft.sv
// sc_fifo_fwft: single-clock first-word-fall-through FIFO; push at full succeeds only alongside a pop
module sc_fifo_fwft #(
  parameter int DW = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  q_clock,
  input  logic                  q_reset,
  input  logic                  push,
  input  logic [DW-1:0]         push_data,
  input  logic                  pop,
  output logic [DW-1:0]         head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);
  logic [DW-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic wr, rd;
  assign rd = pop & ~empty;
  assign wr = push & (~full | rd);
  assign empty = level == '0;
  assign full = level[DEPTH_LOG2];
  assign head = mem[rp];
  always_ff @(posedge q_clock)
    if (wr) mem[wp] <= push_data;
  always_ff @(posedge q_clock or posedge q_reset)
    if (q_reset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + DEPTH_LOG2'(wr);
      rp <= rp + DEPTH_LOG2'(rd);
      level <= level + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(rd);
    end
endmodule

// File: rtl/qsys_host_mailbox.sv
// qsys_host_mailbox: Avalon-MM mailbox with host-to-fabric and fabric-to-host FIFOs and a level interrupt
module qsys_host_mailbox
  import qsys_mailbox_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic          q_clock,
  input  logic          q_reset,
  input  logic [1:0]    avs_address,
  input  logic [DW-1:0] avs_writedata,
  input  logic [3:0]    avs_byteenable,
  input  logic          avs_write,
  input  logic          avs_read,
  input  logic          avs_begintransfer,
  output logic [DW-1:0] avs_readdata,
  output logic          avs_readdatavalid,
  output logic          avs_waitrequest,
  output logic [DW-1:0] h2f_data,
  output logic          h2f_valid,
  input  logic          h2f_ready,
  input  logic [DW-1:0] f2h_data,
  input  logic          f2h_valid,
  output logic          f2h_ready,
  output logic          irq
);
  slv_state_e state, nxt;
  logic [DW-1:0] f2h_head, status, rd_val;
  logic [DEPTH_LOG2:0] h2f_level, f2h_level;
  logic h2f_full, h2f_empty, f2h_full, f2h_empty;
  logic accept, wr_ok, wr_data, rd_data, h2f_pop, ovf_set, unf_set, err_clr;
  logic ovf, unf;
  logic [2:0] irq_en, pending;
  logic unused_ok;
  assign unused_ok = &{1'b0, avs_begintransfer, avs_byteenable[3:1]};
  assign accept = state == S_IDLE && avs_read;
  assign wr_ok = state == S_IDLE && avs_write && !avs_read;
  assign wr_data = wr_ok && avs_address == REG_DATA;
  assign rd_data = accept && avs_address == REG_DATA;
  assign h2f_valid = ~h2f_empty;
  assign h2f_pop = h2f_ready & ~h2f_empty;
  assign f2h_ready = ~f2h_full;
  assign ovf_set = wr_data & h2f_full & ~h2f_pop;
  assign unf_set = rd_data & f2h_empty;
  assign err_clr = wr_ok && avs_address == REG_IRQ_STAT && avs_writedata[PND_ERR];
  assign pending = {ovf | unf, h2f_empty, ~f2h_empty};
  sc_fifo_fwft #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_h2f (
    .q_clock(q_clock), .q_reset(q_reset), .push(wr_data), .push_data(avs_writedata),
    .pop(h2f_pop), .head(h2f_data), .full(h2f_full), .empty(h2f_empty), .level(h2f_level)
  );
  sc_fifo_fwft #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_f2h (
    .q_clock(q_clock), .q_reset(q_reset), .push(f2h_valid & ~f2h_full), .push_data(f2h_data),
    .pop(rd_data), .head(f2h_head), .full(f2h_full), .empty(f2h_empty), .level(f2h_level)
  );
  always_comb begin
    status = '0;
    status[ST_H2F_LVL +: DEPTH_LOG2+1] = h2f_level;
    status[ST_F2H_LVL +: DEPTH_LOG2+1] = f2h_level;
    status[ST_H2F_FULL] = h2f_full;
    status[ST_F2H_EMPTY] = f2h_empty;
    status[ST_OVF] = ovf;
    status[ST_UNF] = unf;
  end
  assign rd_val = avs_address == REG_DATA   ? (f2h_empty ? '0 : f2h_head) :
                  avs_address == REG_STATUS ? status :
                  avs_address == REG_IRQ_EN ? DW'(irq_en) : DW'(pending);
  assign nxt = state == S_IDLE ? (avs_read ? S_RESP : S_IDLE) :
               state == S_RESP ? S_DRAIN : (avs_read ? S_DRAIN : S_IDLE);
  always_ff @(posedge q_clock or posedge q_reset)
    if (q_reset) begin
      state <= S_IDLE;
      avs_readdata <= '0;
      avs_readdatavalid <= 1'b0;
      avs_waitrequest <= 1'b0;
      irq_en <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      irq <= 1'b0;
    end else begin
      state <= nxt;
      avs_waitrequest <= nxt != S_IDLE;
      avs_readdatavalid <= nxt == S_RESP;
      if (accept) avs_readdata <= rd_val;
      if (wr_ok && avs_address == REG_IRQ_EN && avs_byteenable[0]) irq_en <= avs_writedata[2:0];
      ovf <= ovf_set | (ovf & ~err_clr);
      unf <= unf_set | (unf & ~err_clr);
      irq <= |(pending & irq_en);
    end
endmodule

// File: tb/tb_qsys_host_mailbox.sv
// tb_qsys_host_mailbox: directed and randomized checks of the mailbox against a queue-based model
module tb_qsys_host_mailbox;
  logic q_clock = 1'b0, q_reset = 1'b1;
  logic [1:0] avs_address = '0;
  logic [31:0] avs_writedata = '0, avs_readdata, h2f_data, f2h_data = '0;
  logic [3:0] avs_byteenable = 4'hF;
  logic avs_write = 0, avs_read = 0, avs_begintransfer = 0;
  logic avs_readdatavalid, avs_waitrequest, h2f_valid, h2f_ready = 0, f2h_valid = 0, f2h_ready, irq;
  int tests = 0, fails = 0;
  logic [31:0] h2f_q[$], f2h_q[$];
  logic ovf_m = 0, unf_m = 0;
  logic [2:0] irq_en_m = '0;
  logic [31:0] d, r;

  qsys_host_mailbox #(.DW(32), .DEPTH_LOG2(4)) dut (
    .q_clock(q_clock), .q_reset(q_reset), .avs_address(avs_address), .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable), .avs_write(avs_write), .avs_read(avs_read),
    .avs_begintransfer(avs_begintransfer), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
    .h2f_data(h2f_data), .h2f_valid(h2f_valid), .h2f_ready(h2f_ready),
    .f2h_data(f2h_data), .f2h_valid(f2h_valid), .f2h_ready(f2h_ready), .irq(irq)
  );

  always #5 q_clock = ~q_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge q_clock);
    #1;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(h2f_q.size());
    s[12:8] = 5'(f2h_q.size());
    s[16] = h2f_q.size() == 16;
    s[17] = f2h_q.size() == 0;
    s[24] = ovf_m;
    s[25] = unf_m;
    return s;
  endfunction

  function automatic logic exp_irq();
    logic [2:0] p;
    p = {ovf_m | unf_m, h2f_q.size() == 0, f2h_q.size() != 0};
    return |(p & irq_en_m);
  endfunction

  task automatic wait_idle();
    int g = 0;
    while (avs_waitrequest && g < 20) begin tick(); g++; end
    if (g == 20) chk("idle_timeout", avs_waitrequest, 0);
  endtask

  task automatic host_write(input logic [1:0] a, input logic [31:0] v, input logic [3:0] be);
    wait_idle();
    avs_address = a; avs_writedata = v; avs_byteenable = be; avs_write = 1;
    tick();
    avs_write = 0; avs_byteenable = 4'hF;
  endtask

  task automatic host_read(input logic [1:0] a, input int hold, output logic [31:0] v);
    int rdv, g;
    wait_idle();
    avs_address = a; avs_read = 1;
    tick();
    chk("rd_latency", avs_readdatavalid, 1);
    v = avs_readdata; rdv = 1;
    for (int i = 1; i < hold; i++) begin tick(); rdv += int'(avs_readdatavalid); end
    avs_read = 0; g = 0;
    while (avs_waitrequest && g < 10) begin tick(); rdv += int'(avs_readdatavalid); g++; end
    chk("rd_single", rdv, 1);
    chk("rd_done", avs_waitrequest, 0);
  endtask

  task automatic fabric_push(input logic [31:0] v);
    chk("f2h_ready", f2h_ready, 1);
    f2h_valid = 1; f2h_data = v;
    tick();
    f2h_valid = 0;
    f2h_q.push_back(v);
  endtask

  task automatic write_data_m(input logic [31:0] v);
    host_write(2'd0, v, 4'hF);
    if (h2f_q.size() == 16) ovf_m = 1; else h2f_q.push_back(v);
  endtask

  task automatic read_data_m(input int hold);
    logic [31:0] e;
    if (f2h_q.size() == 0) begin e = 0; unf_m = 1; end else e = f2h_q.pop_front();
    host_read(2'd0, hold, d);
    chk("data_rd", d, e);
  endtask

  task automatic read_status_m(input string tag);
    host_read(2'd1, 1, d);
    chk(tag, d, exp_status());
  endtask

  task automatic drain_h2f();
    int g = 0;
    h2f_ready = 1;
    while (h2f_q.size() > 0 && g < 40) begin
      if (h2f_valid) chk("h2f_order", h2f_data, h2f_q.pop_front());
      tick(); g++;
    end
    h2f_ready = 0;
    chk("h2f_drain_left", h2f_q.size(), 0);
    chk("h2f_empty_after", h2f_valid, 0);
  endtask

  initial begin
    repeat (3) tick();
    q_reset = 0;
    tick();
    chk("rst_wait", avs_waitrequest, 0);
    chk("rst_irq", irq, 0);
    chk("rst_f2h_ready", f2h_ready, 1);
    chk("rst_h2f_valid", h2f_valid, 0);
    chk("rst_rdv", avs_readdatavalid, 0);
    host_read(2'd1, 1, d);
    chk("rst_status", d, 32'h0002_0000);

    fabric_push(32'hA5A5_0001);
    fabric_push(32'hA5A5_0002);
    read_data_m(3);
    read_status_m("status_f2h1");

    read_data_m(1);
    host_write(2'd2, 32'h1, 4'hF); irq_en_m = 3'h1;
    tick();
    chk("irq_idle", irq, 0);
    r = $urandom;
    f2h_valid = 1; f2h_data = r;
    tick();
    f2h_valid = 0; f2h_q.push_back(r);
    chk("irq_one_cycle", irq, 0);
    tick();
    chk("irq_two_cycle", irq, 1);
    read_data_m(1);
    chk("irq_clear", irq, 0);

    host_write(2'd2, 32'h7, 4'hE);
    host_read(2'd2, 1, d);
    chk("irq_en_be0", d, 32'h1);

    r = $urandom;
    for (int i = 0; i < 17; i++) write_data_m(r + 32'(i));
    read_status_m("status_full");
    chk("h2f_full_bit", d[16], 1);
    drain_h2f();

    host_write(2'd3, 32'h4, 4'hF); ovf_m = 0;
    read_data_m(1);
    read_status_m("status_unf");
    host_write(2'd2, 32'h4, 4'hF); irq_en_m = 3'h4;
    tick();
    chk("irq_err", irq, exp_irq());
    host_write(2'd3, 32'h3, 4'hF);
    read_status_m("stat_w3_noeffect");
    host_write(2'd3, 32'h4, 4'hF); unf_m = 0;
    tick();
    chk("irq_err_clear", irq, 0);
    read_status_m("status_clr");

    for (int i = 0; i < 5; i++) write_data_m($urandom);
    wait_idle();
    avs_address = 2'd0; avs_read = 1;
    tick();
    tick();
    chk("drain_wait", avs_waitrequest, 1);
    q_reset = 1;
    #1;
    chk("mid_rst_rdv", avs_readdatavalid, 0);
    chk("mid_rst_wait", avs_waitrequest, 0);
    chk("mid_rst_h2f", h2f_valid, 0);
    chk("mid_rst_f2h", f2h_ready, 1);
    avs_read = 0;
    tick();
    q_reset = 0;
    tick();
    h2f_q.delete(); f2h_q.delete(); ovf_m = 0; unf_m = 0; irq_en_m = 0;
    host_read(2'd2, 1, d);
    chk("mid_rst_irq_en", d, 0);
    read_status_m("mid_rst_status");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: if (f2h_q.size() < 16) fabric_push($urandom); else chk("f2h_full_ready", f2h_ready, 0);
        1: write_data_m($urandom);
        2: read_data_m(int'($urandom_range(1, 3)));
        default: read_status_m("rand_status");
      endcase
    end
    read_status_m("rand_final_status");
    drain_h2f();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/qsys_host_mailbox.md
Name: qsys_host_mailbox

Overview:
- Avalon-MM slave directly downstream of the SAM9 host bus bridge, in the q_clock domain (133.33 MHz MCLK).
- Exposes a host-to-fabric (H2F) FIFO and a fabric-to-host (F2H) FIFO through four word registers, plus an interrupt suitable for inr_EVENTS_irq.
- Fabric side uses valid/ready streams.

Parameters:
- DW, 32, data width of FIFOs and bus.
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries).

Ports:
- q_clock  in  1  clock
- q_reset  in  1  reset
- avs_address  in  2  word offset
- avs_writedata  in  DW  write data
- avs_byteenable  in  4  byte lanes
- avs_write  in  1  write strobe
- avs_read  in  1  read strobe
- avs_begintransfer  in  1  informational, unused
- avs_readdata  out  DW  read data
- avs_readdatavalid  out  1  read response strobe
- avs_waitrequest  out  1  slave stall
- h2f_data  out  DW  H2F FIFO head
- h2f_valid  out  1  H2F not empty
- h2f_ready  in  1  fabric pop
- f2h_data  in  DW  fabric data
- f2h_valid  in  1  fabric push
- f2h_ready  out  1  F2H not full
- irq  out  1  level interrupt

Reset and clock: reset q_reset, asynchronous, active-high; clock q_clock.

Behaviour:
- Reset values: readdata=0, readdatavalid=0, waitrequest=0, irq=0, irq_en=0, sticky bits=0. Both FIFOs are empty, so h2f_valid=0 and f2h_ready=1.

Register map (word offset):
- 0 DATA:
  - A write pushes writedata into H2F; byteenable is ignored.
  - A read pops F2H and returns its head.
- 1 STATUS (RO):
  - [DEPTH_LOG2:0] H2F level.
  - [8+DEPTH_LOG2:8] F2H level.
  - [16] H2F full.
  - [17] F2H empty.
  - [24] overflow sticky.
  - [25] underflow sticky.
- 2 IRQ_EN (RW, bits [2:0]):
  - The write takes effect only if byteenable[0]=1.
  - Read returns the value zero-extended.
- 3 IRQ_STAT:
  - Read returns pending[2:0].
  - Writing 1 to bit2 clears both sticky bits; writing 1 to bits 0/1 has no effect.
- Pending bits:
  - pending[0] = F2H not empty.
  - pending[1] = H2F empty.
  - pending[2] = overflow|underflow.

Slave FSM:
- IDLE: waitrequest=0.
  - read: accept, capture readdata, go to RESP.
  - write (no read): perform the write, stay in IDLE.
  - read and write together: read wins; the write is held by the following waitrequest.
- RESP: readdatavalid=1, waitrequest=1, go to DRAIN.
- DRAIN: waitrequest=1; return to IDLE on the first cycle with read=0.
- Read latency is exactly 1 cycle from accept to readdatavalid.
- A read that is held high across RESP/DRAIN must not cause a second pop.

FIFO rules:
- A push to a full H2F is dropped and sets overflow.
- A pop of an empty F2H returns 0 and sets underflow.
- f2h_valid&f2h_ready pushes F2H; h2f_valid&h2f_ready pops H2F.
- Push and pop of the same FIFO in one cycle: level unchanged, data order preserved; valid also at full and at empty (at empty the pop side sees valid=0, so only the push occurs).
- STATUS reflects levels registered before the current cycle's push/pop.
- Pointers wrap modulo 2^DEPTH_LOG2; the level counter is DEPTH_LOG2+1 bits.
- Sticky set and clear in the same cycle: set wins.

Interrupt:
- irq is registered: irq <= |(pending & irq_en), one cycle after the condition.

Reset mid-operation:
- Reset during RESP/DRAIN returns to IDLE with readdatavalid=0 and flushes both FIFOs.

Decomposition:
- Package qsys_mailbox_pkg holds:
  - register offsets REG_DATA=0, REG_STATUS=1, REG_IRQ_EN=2, REG_IRQ_STAT=3;
  - STATUS bit positions;
  - pending bit indices;
  - slave FSM state enum.
- Sub-module sc_fifo_fwft (DW, DEPTH_LOG2), instantiated twice:
  - ports: push, push_data, pop, head, full, empty, level;
  - first-word-fall-through behaviour.

Test Plan:
1. Reset → waitrequest=0, irq=0, f2h_ready=1, h2f_valid=0; read STATUS → 0x00020000.
2. Fabric pushes 0xA5A50001 and 0xA5A50002. Read DATA with read held 3 cycles → exactly one readdatavalid, one cycle after accept, readdata=0xA5A50001. STATUS[12:8]=1.
3. Host writes 17 words 0..16 to DATA with h2f_ready=0 → STATUS[16]=1, STATUS[4:0]=16, bit24=1. Then h2f_ready=1 → drains 0..15 in order, word 16 absent.
4. IRQ_EN=0x1, fabric pushes one word → irq=1 two cycles after f2h_valid. Host pops it → irq=0 two cycles later.
5. Read DATA with F2H empty → readdata=0, STATUS[25]=1. Write IRQ_STAT=0x4 → STATUS[25]=0; with IRQ_EN=0x4, irq drops.
6. Assert q_reset while in DRAIN with 5 words in H2F → readdatavalid=0, waitrequest=0, h2f_valid=0, IRQ_EN=0.
